score_play_ctrl: RTL

Playback sequencer for the note-to-audio datapath. It starts random or saved score playback and issues `Init_audio_video` and the `Do_rand_audio_video`/`Do_save_audio_video` enables. It times each note in audio-sample ticks from the score's length field and a tempo setting, then pulses `finish_len` to advance `score_noteAdr`. It sits between the top-level control FSM / user keys and `note_to_audio`.

---
 rtl/piano_pkg.sv | 10 +
 rtl/score_play_ctrl_note_timer.sv | 55 +++++
 rtl/score_play_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/piano_pkg.sv
// Shared types and constants for the score playback path.
package piano_pkg;

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_FETCH, S_PLAY, S_DONE} play_state_t;

  typedef enum logic {MODE_RAND, MODE_SAVE} play_mode_t;

  localparam int unsigned SAVE_SCORE_LEN = 43;

endpackage

// File: rtl/score_play_ctrl_note_timer.sv
// Note duration timer: latches length x tempo, counts sample ticks,
// flags the final tick of the note and the articulation gap window.
module note_timer #(
  parameter int unsigned LEN_W   = 3,
  parameter int unsigned TEMPO_W = 16,
  parameter int unsigned GAP     = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               clear,
  input  logic               tick,
  input  logic [LEN_W-1:0]   note_len,
  input  logic [TEMPO_W-1:0] tempo,
  output logic               expire,
  output logic               in_gap
);

  localparam int unsigned DUR_W = LEN_W + TEMPO_W;
  localparam logic [DUR_W-1:0] GAP_D = DUR_W'(GAP);

  logic [DUR_W-1:0]   dur_q;
  logic [DUR_W-1:0]   cnt_q;
  logic [DUR_W-1:0]   prod;
  logic [LEN_W-1:0]   len_eff;
  logic [TEMPO_W-1:0] tempo_eff;

  // Zero length or tempo is treated as one, so every note lasts at least one tick
  always_comb begin
    len_eff   = (note_len == '0) ? LEN_W'(1) : note_len;
    tempo_eff = (tempo == '0) ? TEMPO_W'(1) : tempo;
    prod      = DUR_W'(len_eff) * DUR_W'(tempo_eff);
  end

  // Duration latch and sample counter; clear has priority over tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dur_q <= '0;
      cnt_q <= '0;
    end else begin
      if (load) begin
        dur_q <= prod;
      end
      if (clear) begin
        cnt_q <= '0;
      end else if (tick) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign expire = tick && (cnt_q == dur_q - 1'b1);
  assign in_gap = (dur_q > GAP_D) && (cnt_q >= dur_q - GAP_D);

endmodule

// File: rtl/score_play_ctrl.sv
// Playback sequencer: starts random/saved score playback, times each
// note in sample ticks and advances the note address via finish_len.
module score_play_ctrl
  import piano_pkg::*;
#(
  parameter int unsigned LEN_W   = 3,
  parameter int unsigned TEMPO_W = 16,
  parameter int unsigned GAP     = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_rand,
  input  logic               start_save,
  input  logic               stop,
  input  logic               sample_tick,
  input  logic [LEN_W-1:0]   note_len,
  input  logic [TEMPO_W-1:0] tempo,
  input  logic               Done_rand_audio,
  input  logic               Done_save_audio,
  output logic               Init_audio_video,
  output logic               Do_rand_audio_video,
  output logic               Do_save_audio_video,
  output logic               finish_len,
  output logic               mute,
  output logic               busy,
  output logic               play_done
);

  play_state_t state_q;
  play_state_t state_d;
  play_mode_t  mode_q;
  play_mode_t  mode_d;
  logic        fetch2_q;
  logic        done_cur;
  logic        active_d;
  logic        timer_load;
  logic        timer_tick;
  logic        expire;
  logic        in_gap;
  logic        mute_q;

  // Ticks only count in PLAY, and a tick coinciding with stop is dropped
  assign timer_tick = sample_tick && (state_q == S_PLAY) && !stop;

  note_timer #(
    .LEN_W   (LEN_W),
    .TEMPO_W (TEMPO_W),
    .GAP     (GAP)
  ) u_note_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .clear    (timer_load),
    .tick     (timer_tick),
    .note_len (note_len),
    .tempo    (tempo),
    .expire   (expire),
    .in_gap   (in_gap)
  );

  // Next-state and mode selection; stop overrides everything outside IDLE
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    timer_load = 1'b0;
    done_cur   = (mode_q == MODE_SAVE) ? Done_save_audio : Done_rand_audio;
    case (state_q)
      S_IDLE: begin
        if (start_save) begin
          state_d = S_INIT;
          mode_d  = MODE_SAVE;
        end else if (start_rand) begin
          state_d = S_INIT;
          mode_d  = MODE_RAND;
        end
      end
      S_INIT:  state_d = stop ? S_IDLE : S_FETCH;
      S_FETCH: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (fetch2_q) begin
          if (done_cur) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_PLAY;
            timer_load = 1'b1;
          end
        end
      end
      S_PLAY: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (expire) begin
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    active_d = (state_d == S_INIT) || (state_d == S_FETCH) || (state_d == S_PLAY);
  end

  // State register with outputs registered from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q             <= S_IDLE;
      mode_q              <= MODE_RAND;
      fetch2_q            <= 1'b0;
      Init_audio_video    <= 1'b0;
      Do_rand_audio_video <= 1'b0;
      Do_save_audio_video <= 1'b0;
      finish_len          <= 1'b0;
      mute_q              <= 1'b1;
      busy                <= 1'b0;
      play_done           <= 1'b0;
    end else begin
      state_q             <= state_d;
      mode_q              <= mode_d;
      fetch2_q            <= (state_q == S_FETCH) && (state_d == S_FETCH);
      Init_audio_video    <= (state_d == S_INIT);
      Do_rand_audio_video <= active_d && (mode_d == MODE_RAND);
      Do_save_audio_video <= active_d && (mode_d == MODE_SAVE);
      finish_len          <= expire;
      mute_q              <= (state_d == S_IDLE);
      busy                <= (state_d != S_IDLE);
      play_done           <= (state_d == S_DONE);
    end
  end

  // Gap mute follows the live counter so it starts on the exact tick
  assign mute = mute_q || ((state_q == S_PLAY) && in_gap);

endmodule
